// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT bits per clock through one digit slice.
// Optional subtract mode (a + ~b + 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout,
    output logic             o_ovf,
    output logic [1:0]       o_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [DIGIT:0]   w_dsum;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_acc_next;

    // Operands are only captured outside RUN, so start during RUN is ignored.
    assign w_accept = i_start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = i_sub ? ~i_b : i_b;
    assign w_c_load = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_load = i_b;
    assign w_c_load = i_cin;
`endif

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
    // Carry into the digit MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
    assign w_cmsb     = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
    assign w_acc_next = WIDTH'({w_dsum[DIGIT-1:0], r_acc} >> DIGIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = i_start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state == S_RUN);
        o_done  = (r_state == S_DONE);
        o_state = r_state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + 1'b1;
            r_acc   <= w_acc_next;
            if (w_last) begin
                r_s    <= w_acc_next;
                r_cout <= w_dsum[DIGIT];
                r_ovf  <= w_cmsb ^ w_dsum[DIGIT];
            end
        end
    end

    assign o_s    = r_s;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (1x1, 8x1, 8x4) checked through result/latency scoreboards.
// Subtract vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       w1_start, w1_a, w1_b, w1_cin;
    logic       w1_busy, w1_done, w1_s, w1_cout, w1_ovf;
    logic [1:0] w1_state;

    logic       d1_start, d1_cin, d1_busy, d1_done, d1_cout, d1_ovf;
    logic [7:0] d1_a, d1_b, d1_s;
    logic [1:0] d1_state;

    logic       d4_start, d4_cin, d4_busy, d4_done, d4_cout, d4_ovf;
    logic [7:0] d4_a, d4_b, d4_s;
    logic [1:0] d4_state;

`ifdef SERIAL_ADDER_SUB_EN
    logic w1_sub = 1'b0;
    logic d1_sub = 1'b0;
    logic d4_sub = 1'b0;
`endif

    serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_start(w1_start), .i_a(w1_a), .i_b(w1_b), .i_cin(w1_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub(w1_sub),
`endif
        .o_busy(w1_busy), .o_done(w1_done), .o_s(w1_s), .o_cout(w1_cout), .o_ovf(w1_ovf),
        .o_state(w1_state)
    );

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_start(d1_start), .i_a(d1_a), .i_b(d1_b), .i_cin(d1_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub(d1_sub),
`endif
        .o_busy(d1_busy), .o_done(d1_done), .o_s(d1_s), .o_cout(d1_cout), .o_ovf(d1_ovf),
        .o_state(d1_state)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_start(d4_start), .i_a(d4_a), .i_b(d4_b), .i_cin(d4_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub(d4_sub),
`endif
        .o_busy(d4_busy), .o_done(d4_done), .o_s(d4_s), .o_cout(d4_cout), .o_ovf(d4_ovf),
        .o_state(d4_state)
    );

    // Expected {cout, ovf, s} and the cycle count at which done must be seen.
    logic [2:0] exp_q1[$];
    int         t_q1[$];
    logic [9:0] exp_q8[$];
    int         t_q8[$];
    logic [9:0] exp_q4[$];
    int         t_q4[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop and compare whenever an instance presents done.
    logic [2:0] e1;
    int         te1;
    always @(negedge clk) begin
        if (!rst && w1_done) begin
            if (exp_q1.size() == 0) begin
                check("w1_unexpected_done", 1, 0);
            end else begin
                e1  = exp_q1.pop_front();
                te1 = t_q1.pop_front();
                check("w1_result", {29'd0, w1_cout, w1_ovf, w1_s}, {29'd0, e1});
                check("w1_done_cycle", cyc, te1);
            end
        end
    end

    logic [9:0] e8;
    int         te8;
    always @(negedge clk) begin
        if (!rst && d1_done) begin
            if (exp_q8.size() == 0) begin
                check("d1_unexpected_done", 1, 0);
            end else begin
                e8  = exp_q8.pop_front();
                te8 = t_q8.pop_front();
                check("d1_result", {22'd0, d1_cout, d1_ovf, d1_s}, {22'd0, e8});
                check("d1_done_cycle", cyc, te8);
            end
        end
    end

    logic [9:0] e4;
    int         te4;
    always @(negedge clk) begin
        if (!rst && d4_done) begin
            if (exp_q4.size() == 0) begin
                check("d4_unexpected_done", 1, 0);
            end else begin
                e4  = exp_q4.pop_front();
                te4 = t_q4.pop_front();
                check("d4_result", {22'd0, d4_cout, d4_ovf, d4_s}, {22'd0, e4});
                check("d4_done_cycle", cyc, te4);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            w1_start = 1'b0;
            d1_start = 1'b0;
            d4_start = 1'b0;
        end
    endtask

    // Full-adder reference for the 1-bit instance; start edge is cyc+1, done one edge later.
    task automatic op1(input logic a, input logic b, input logic c);
        logic [1:0] sum;
        @(negedge clk);
        w1_a = a; w1_b = b; w1_cin = c; w1_start = 1'b1;
        sum = {1'b0, a} + {1'b0, b} + {1'b0, c};
        exp_q1.push_back({sum[1], c ^ sum[1], sum[0]});
        t_q1.push_back(cyc + 2);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic push, input logic [9:0] e);
        @(negedge clk);
        d1_a = a; d1_b = b; d1_cin = c; d1_start = 1'b1;
        if (push) begin
            exp_q8.push_back(e);
            t_q8.push_back(cyc + 9);
        end
    endtask

    task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [9:0] e);
        @(negedge clk);
        d4_a = a; d4_b = b; d4_cin = c; d4_start = 1'b1;
        exp_q4.push_back(e);
        t_q4.push_back(cyc + 3);
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((exp_q1.size() + exp_q8.size() + exp_q4.size()) != 0 && k < bound) begin
            step(1);
            k++;
        end
        check("drain_pending", exp_q1.size() + exp_q8.size() + exp_q4.size(), 0);
        step(2);
    endtask

    initial begin
        int bc;
        w1_start = 0; w1_a = 0; w1_b = 0; w1_cin = 0;
        d1_start = 0; d1_a = 0; d1_b = 0; d1_cin = 0;
        d4_start = 0; d4_a = 0; d4_b = 0; d4_cin = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("w1_reset_outputs", {w1_busy, w1_done, w1_s, w1_cout, w1_ovf, w1_state}, 0);
        check("d1_reset_outputs", {d1_busy, d1_done, d1_s, d1_cout, d1_ovf, d1_state}, 0);
        check("d4_reset_outputs", {d4_busy, d4_done, d4_s, d4_cout, d4_ovf, d4_state}, 0);
        step(2);
        rst = 1'b0;

        // 1-bit full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            op1(v[2], v[1], v[0]);
            step(3);
        end
        drain(10);

        // 8x1: wrap to zero with carry; busy spans exactly eight cycles.
        op8(8'hFF, 8'h01, 1'b0, 1'b1, {1'b1, 1'b0, 8'h00});
        bc = 0;
        repeat (10) begin
            step(1);
            if (d1_busy) bc++;
        end
        check("d1_busy_cycles", bc, 8);
        drain(20);
        op8(8'h7F, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 8'h80});
        drain(20);

        // 8x4: signed overflow, then back-to-back start held in the done cycle.
        op4(8'h3C, 8'h4B, 1'b1, {1'b0, 1'b1, 8'h88});
        step(2);
        op4(8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 8'h02});
        check("d4_b2b_done_high", d4_done, 1);
        drain(20);
        op4(8'hF0, 8'h10, 1'b0, {1'b1, 1'b0, 8'h00});
        drain(20);

        // Start mid-RUN with other operands must be ignored.
        op8(8'h55, 8'h33, 1'b1, 1'b1, {1'b0, 1'b1, 8'h89});
        step(3);
        @(negedge clk);
        d1_a = 8'hFF; d1_b = 8'hFF; d1_cin = 1'b1; d1_start = 1'b1;
        step(1);
        drain(20);

        // Reset after RUN edge 4 discards the operation without a done pulse.
        op8(8'h12, 8'h34, 1'b0, 1'b0, 10'd0);
        step(4);
        check("d1_busy_before_reset", d1_busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("d1_midrun_reset_outputs", {d1_busy, d1_done, d1_s, d1_cout, d1_ovf, d1_state}, 0);
        step(2);
        rst = 1'b0;
        step(12);
        op8(8'hA0, 8'hC0, 1'b1, 1'b1, {1'b1, 1'b1, 8'h61});
        drain(20);

`ifdef SERIAL_ADDER_SUB_EN
        d1_sub = 1'b1;
        op8(8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE});
        drain(20);
        op8(8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h7F});
        drain(20);
        d1_sub = 1'b0;
        op8(8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'h0D});
        drain(20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, through one DIGIT-wide full-adder slice and a registered carry.
- Successor to the single-bit combinational full adder. Used where area matters more than latency (datapath accumulators, checksum units).
- Start/busy/done handshake. Results are held until the next accepted start.

Parameters:
- WIDTH, default 8: operand and sum width in bits; WIDTH >= 1.
- DIGIT, default 1: bits processed per cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request. Sampled only when idle or done.
- a, input, WIDTH: operand A. Captured on the accepted start edge.
- b, input, WIDTH: operand B. Captured on the accepted start edge.
- cin, input, 1: carry-in. Captured on the accepted start edge.
- busy, output, 1: high while digits are being processed.
- done, output, 1: one-cycle pulse; s, cout and ovf are valid from this cycle on.
- s, output, WIDTH: sum.
- cout, output, 1: carry-out of the MSB.
- ovf, output, 1: signed overflow, equal to carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0. Shift registers, carry and digit counter are cleared. Any in-flight operation is discarded with no done pulse.
- States:
  - IDLE: on start=1, load the A/B shift registers with a/b, set carry=cin, counter=0, go to RUN.
  - RUN: each edge adds the low DIGIT bits of A, B and carry. The DIGIT-bit result is shifted into the sum register from the MSB end, A and B shift right by DIGIT, carry updates, counter increments. On the edge where counter==NDIG-1, go to DONE and update s, cout and ovf. ovf uses the carry into the MSB of the final digit.
  - DONE: done=1 for exactly one cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back).
- busy=1 in RUN only. start in RUN is ignored; a, b and cin changes in RUN have no effect.
- Latency: start sampled at edge 0; RUN occupies edges 1..NDIG; done is high during the cycle after edge NDIG. Throughput is one result per NDIG+1 cycles.
- s, cout and ovf change only on the final RUN edge or at reset. They hold between operations.
- Arithmetic: {cout,s} = a + b + cin, unsigned, mod 2^(WIDTH+1).
- WIDTH=1, DIGIT=1 degenerates to a registered full adder with 2-cycle latency.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1 computes a + ~b + 1; cin is ignored. cout=1 means no borrow (a >= b unsigned). ovf is the signed overflow of the subtraction.
  - sub=0 behaves exactly as the base adder.
- Undefined: no sub port; add only.

Test Plan:
- WIDTH=1, DIGIT=1: apply all 8 {a,b,cin} combinations via start pulses -> {cout,s} matches the full-adder truth table (e.g. 1,1,1 -> cout=1, s=1); done 2 cycles after each start edge.
- WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, ovf=0; busy high for 8 cycles; done exactly 9 cycles after the start edge. Then a=8'h7F, b=8'h01 -> s=8'h80, cout=0, ovf=1.
- WIDTH=8, DIGIT=4: a=8'h3C, b=8'h4B, cin=1 -> s=8'h88, cout=0, ovf=1; done 3 cycles after start. Then start held high in the done cycle with a=8'h01, b=8'h01, cin=0 -> second op accepted, s=8'h02 three cycles later.
- Start pulsed mid-RUN with different operands -> ignored; the original result is delivered. Assert rst on RUN edge 4 -> all outputs 0 immediately; no done pulse; the next op completes normally.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1, a=8'h05, b=8'h07, cin=1 -> s=8'hFE, cout=0, ovf=0. Then a=8'h80, b=8'h01 -> s=8'h7F, cout=1, ovf=1.
